// File: rtl/stencil_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stencil_host_pkg
// Description : Command opcodes, solver pin modes and sequencer state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package stencil_host_pkg;

    localparam logic [1:0] C_OP_RUN    = 2'd0;
    localparam logic [1:0] C_OP_WRITE  = 2'd1;
    localparam logic [1:0] C_OP_READ   = 2'd2;
    localparam logic [1:0] C_OP_CONFIG = 2'd3;

    localparam logic [1:0] C_MODE_RUN    = 2'b00;
    localparam logic [1:0] C_MODE_WRITE  = 2'b01;
    localparam logic [1:0] C_MODE_READ   = 2'b10;
    localparam logic [1:0] C_MODE_CONFIG = 2'b11;

    localparam logic [2:0] C_ST_IDLE    = 3'd0;
    localparam logic [2:0] C_ST_CFG     = 3'd1;
    localparam logic [2:0] C_ST_WR      = 3'd2;
    localparam logic [2:0] C_ST_RUN     = 3'd3;
    localparam logic [2:0] C_ST_RD_REQ  = 3'd4;
    localparam logic [2:0] C_ST_RD_WAIT = 3'd5;
    localparam logic [2:0] C_ST_RD_OUT  = 3'd6;

endpackage
`default_nettype wire

// File: rtl/stencil_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : stencil_host_seq
// Description : Host-side command sequencer driving the stencil solver pins.
// Revision    : 1.0 - initial release
// ============================================================================
module stencil_host_seq
    import stencil_host_pkg::*;
#(
    parameter int READ_LAT = 2,
    parameter int RUN_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [5:0]       cmd_addr,
    input  logic [6:0]       cmd_len,
    input  logic [7:0]       cmd_data,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    input  logic             rd_ready,
    output logic [7:0]       pin_ui,
    output logic [7:0]       pin_uio,
    input  logic [7:0]       pin_uio_in,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0]       C_LAT_INIT = 8'(READ_LAT - 1);
    localparam logic [RUN_W-1:0] C_RUN_ONE  = RUN_W'(1);

    logic [2:0]       r_state, w_state_nxt;
    logic [5:0]       r_addr, w_addr_nxt;
    logic [6:0]       r_cnt, w_cnt_nxt;
    logic [RUN_W-1:0] r_run, w_run_nxt;
    logic [7:0]       r_lat, w_lat_nxt;
    logic [7:0]       w_pin_ui_nxt, w_pin_uio_nxt;
    logic             w_done_nxt, w_rd_valid_nxt, w_capture;

    assign cmd_ready = (r_state == C_ST_IDLE) && !done;
    assign busy      = (r_state != C_ST_IDLE);
    // A beat is only consumed while cells remain; the cnt==0 cycle lets the last write reach the pins.
    assign wr_ready  = (r_state == C_ST_WR) && (r_cnt != 7'd0) && wr_valid;

    // Pins are registered from the next-state decision, so they line up with the state they belong to.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_cnt_nxt      = r_cnt;
        w_run_nxt      = r_run;
        w_lat_nxt      = r_lat;
        w_pin_ui_nxt   = 8'h00;
        w_pin_uio_nxt  = 8'h00;
        w_done_nxt     = 1'b0;
        w_rd_valid_nxt = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_addr_nxt = cmd_addr;
                    w_cnt_nxt  = cmd_len;
                    w_run_nxt  = run_cycles;
                    w_lat_nxt  = C_LAT_INIT;
                    case (cmd_op)
                        C_OP_CONFIG: begin
                            w_state_nxt   = C_ST_CFG;
                            w_pin_ui_nxt  = {C_MODE_CONFIG, 6'd0};
                            w_pin_uio_nxt = cmd_data;
                        end
                        C_OP_RUN: begin
                            if (run_cycles == '0) w_done_nxt  = 1'b1;
                            else                  w_state_nxt = C_ST_RUN;
                        end
                        C_OP_WRITE: begin
                            if (cmd_len == 7'd0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt  = C_ST_WR;
                                w_pin_ui_nxt = {C_MODE_READ, cmd_addr};
                            end
                        end
                        C_OP_READ: begin
                            if (cmd_len == 7'd0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt  = C_ST_RD_REQ;
                                w_pin_ui_nxt = {C_MODE_READ, cmd_addr};
                            end
                        end
                        default: ;
                    endcase
                end
            end
            C_ST_CFG: begin
                w_state_nxt = C_ST_IDLE;
                w_done_nxt  = 1'b1;
            end
            C_ST_RUN: begin
                w_pin_ui_nxt = {C_MODE_RUN, 6'd0};
                if (r_run == C_RUN_ONE) begin
                    w_state_nxt  = C_ST_IDLE;
                    w_done_nxt   = 1'b1;
                    w_pin_ui_nxt = 8'h00;
                end else begin
                    w_run_nxt = r_run - C_RUN_ONE;
                end
            end
            C_ST_WR: begin
                if (r_cnt == 7'd0) begin
                    w_state_nxt = C_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (wr_valid) begin
                    w_pin_ui_nxt  = {C_MODE_WRITE, r_addr};
                    w_pin_uio_nxt = wr_data;
                    w_addr_nxt    = r_addr + 6'd1;
                    w_cnt_nxt     = r_cnt - 7'd1;
                end else begin
                    w_pin_ui_nxt = {C_MODE_READ, r_addr};
                end
            end
            C_ST_RD_REQ, C_ST_RD_WAIT: begin
                w_pin_ui_nxt = {C_MODE_READ, r_addr};
                if (r_lat == 8'd0) begin
                    w_capture      = 1'b1;
                    w_rd_valid_nxt = 1'b1;
                    w_state_nxt    = C_ST_RD_OUT;
                end else begin
                    w_lat_nxt   = r_lat - 8'd1;
                    w_state_nxt = C_ST_RD_WAIT;
                end
            end
            C_ST_RD_OUT: begin
                if (rd_ready) begin
                    w_addr_nxt = r_addr + 6'd1;
                    w_cnt_nxt  = r_cnt - 7'd1;
                    if (r_cnt == 7'd1) begin
                        w_state_nxt = C_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt  = C_ST_RD_REQ;
                        w_lat_nxt    = C_LAT_INIT;
                        w_pin_ui_nxt = {C_MODE_READ, r_addr + 6'd1};
                    end
                end else begin
                    w_rd_valid_nxt = 1'b1;
                    w_pin_ui_nxt   = {C_MODE_READ, r_addr};
                end
            end
            default: w_state_nxt = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= C_ST_IDLE;
            r_addr   <= 6'd0;
            r_cnt    <= 7'd0;
            r_run    <= '0;
            r_lat    <= 8'd0;
            pin_ui   <= 8'h00;
            pin_uio  <= 8'h00;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_run    <= w_run_nxt;
            r_lat    <= w_lat_nxt;
            pin_ui   <= w_pin_ui_nxt;
            pin_uio  <= w_pin_uio_nxt;
            rd_valid <= w_rd_valid_nxt;
            done     <= w_done_nxt;
            if (w_capture) rd_data <= pin_uio_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stencil_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_stencil_host_seq
// Description : Self-checking bench with a solver memory model and reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stencil_host_seq;

    logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_addr = 6'd0;
    logic [6:0]  cmd_len = 7'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic [15:0] run_cycles = 16'd0;
    logic        wr_valid = 1'b0, rd_ready = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        cmd_ready, wr_ready, rd_valid, busy, done;
    logic [7:0]  rd_data, pin_ui, pin_uio, pin_uio_in;

    stencil_host_seq #(.READ_LAT(2), .RUN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .run_cycles(run_cycles), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .pin_ui(pin_ui),
        .pin_uio(pin_uio), .pin_uio_in(pin_uio_in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Solver model: 64-cell memory, writes on mode 01, read data one register behind the request.
    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];
    logic [7:0] rd_pipe;
    logic       preload = 1'b1;

    function automatic logic [7:0] init_val(input int i);
        if (i == 8) return 8'h80;
        if (i == 9) return 8'h7F;
        return 8'(i * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        else if (pin_ui[7:6] == 2'b01) mem[pin_ui[5:0]] <= pin_uio;
        rd_pipe <= (pin_ui[7:6] == 2'b10) ? mem[pin_ui[5:0]] : 8'hEE;
    end
    assign pin_uio_in = rd_pipe;

    int n_checks = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] obs_ui[$], obs_uio[$], wr_q[$], rd_got[$];
    int done_idx, hs_idx, wr_rdy_cnt, rd_vld_cnt;

    // Issue one command and follow it to completion, comparing against the reference memory.
    task automatic exec(input logic [1:0] op, input logic [5:0] a, input logic [6:0] l,
                        input logic [7:0] d, input logic [15:0] rc,
                        input int stall_at, input int stall_n, input bit rnd);
        int beats = 0, stalls = 0, holds = 0, cyc = 0, exp_done, nwr, errs, nz;
        check("cmd_ready_at_issue", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_data = d; run_cycles = rc;
        @(negedge clk);
        cmd_valid = 1'b0;
        obs_ui.delete(); obs_uio.delete(); wr_q.delete(); rd_got.delete();
        done_idx = -1; hs_idx = -1; wr_rdy_cnt = 0; rd_vld_cnt = 0;
        while (cyc < 4000) begin
            obs_ui.push_back(pin_ui);
            obs_uio.push_back(pin_uio);
            if (done) begin done_idx = cyc; break; end
            if (rnd) wr_valid = ($urandom_range(0, 3) != 0);
            else if (beats == stall_at && stalls < stall_n) begin wr_valid = 1'b0; stalls++; end
            else wr_valid = 1'b1;
            wr_data = rnd ? 8'($urandom) : 8'hFF;
            if (rnd) rd_ready = ($urandom_range(0, 2) != 0);
            else if (rd_valid && rd_got.size() == 0 && holds < stall_n) begin rd_ready = 1'b0; holds++; end
            else rd_ready = 1'b1;
            #1;
            if (wr_ready) wr_rdy_cnt++;
            if (rd_valid) rd_vld_cnt++;
            if (wr_valid && wr_ready) begin wr_q.push_back(wr_data); beats++; end
            if (rd_valid && rd_ready) begin rd_got.push_back(rd_data); if (hs_idx < 0) hs_idx = cyc; end
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("done_seen", done_idx >= 0, 1);
        check("cmd_ready_in_done", cmd_ready, 0);
        exp_done = (op == 2'd3) ? 1 : (op == 2'd0) ? int'(rc) : (l == 7'd0) ? 0 : -1;
        if (exp_done >= 0) check("done_latency", done_idx, exp_done);
        nwr = 0; errs = 0; nz = 0;
        foreach (obs_ui[i]) begin
            if (obs_ui[i] != 8'h00) nz++;
            if (obs_ui[i][7:6] == 2'b01) begin
                if (nwr >= wr_q.size() || obs_ui[i][5:0] != 6'(a + nwr) || obs_uio[i] != wr_q[nwr]) errs++;
                nwr++;
            end
        end
        check("write_count", nwr, (op == 2'd1) ? 32'(l) : 32'd0);
        check("write_addr_data", errs, 0);
        if (op == 2'd1) for (int i = 0; i < wr_q.size(); i++) ref_mem[6'(a + i)] = wr_q[i];
        if (op == 2'd2) begin
            errs = 0;
            foreach (rd_got[i]) if (rd_got[i] !== ref_mem[6'(a + i)]) errs++;
            check("read_count", rd_got.size(), 32'(l));
            check("read_data", errs, 0);
        end
        if (op != 2'd1 || l == 7'd0) check("wr_ready_idle", wr_rdy_cnt, 0);
        if (op != 2'd2) check("rd_valid_idle", rd_vld_cnt, 0);
        if (op == 2'd0 || (op != 2'd3 && l == 7'd0)) check("no_pin_activity", nz, 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("pins_idle", {pin_ui, pin_uio}, 16'h0000);
        check("cmd_ready_after", cmd_ready, 1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [6:0]  len;
        logic [7:0]  data;
        logic [15:0] rc;
        int          pidx;
        logic [7:0]  exp_ui;
        logic [7:0]  exp_uio;
        int          exp_done;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int first_w, last_w, n10, early, late, errs;
        tbl[0] = '{2'd3, 6'd0,  7'd0, 8'h40, 16'd0, 0, 8'hC0, 8'h40, 1};
        tbl[1] = '{2'd3, 6'd7,  7'd0, 8'hA5, 16'd0, 0, 8'hC0, 8'hA5, 1};
        tbl[2] = '{2'd0, 6'd0,  7'd0, 8'h00, 16'd0, 0, 8'h00, 8'h00, 0};
        tbl[3] = '{2'd0, 6'd0,  7'd0, 8'h00, 16'd3, 0, 8'h00, 8'h00, 3};
        tbl[4] = '{2'd1, 6'd12, 7'd0, 8'h00, 16'd0, 0, 8'h00, 8'h00, 0};
        tbl[5] = '{2'd2, 6'd30, 7'd0, 8'h00, 16'd0, 0, 8'h00, 8'h00, 0};
        tbl[6] = '{2'd2, 6'd5,  7'd1, 8'h00, 16'd0, 0, 8'h85, 8'h00, 3};
        tbl[7] = '{2'd1, 6'd63, 7'd1, 8'h00, 16'd0, 1, 8'h7F, 8'hFF, 2};
        tbl[8] = '{2'd0, 6'd0,  7'd0, 8'h00, 16'd1, 0, 8'h00, 8'h00, 1};
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

        repeat (3) @(negedge clk);
        check("rst_pins", {pin_ui, pin_uio}, 16'h0000);
        check("rst_rd", {rd_valid, rd_data}, 9'h000);
        check("rst_flags", {done, busy, wr_ready}, 3'b000);
        preload = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);

        foreach (tbl[k]) begin
            exec(tbl[k].op, tbl[k].addr, tbl[k].len, tbl[k].data, tbl[k].rc, 0, 0, 1'b0);
            check($sformatf("vec%0d_pin_ui", k), obs_ui[tbl[k].pidx], tbl[k].exp_ui);
            check($sformatf("vec%0d_pin_uio", k), obs_uio[tbl[k].pidx], tbl[k].exp_uio);
            check($sformatf("vec%0d_done_at", k), done_idx, tbl[k].exp_done);
        end

        // Two-cell read, first beat held off by rd_ready for 4 cycles.
        exec(2'd2, 6'd8, 7'd2, 8'h00, 16'd0, 0, 4, 1'b0);
        check("rd_beat0", rd_got[0], 8'h80);
        check("rd_beat1", rd_got[1], 8'h7F);
        check("rd_hold_handshake", hs_idx, 2 + 4);
        early = 0; late = 0;
        foreach (obs_ui[i]) if (obs_ui[i] == 8'h89) begin
            if (i <= hs_idx) early++; else late++;
        end
        check("rd_second_req_early", early, 0);
        check("rd_second_req_seen", late > 0, 1);

        // Wrapping 32-beat write with a 3-cycle gap after beat 10.
        exec(2'd1, 6'd56, 7'd32, 8'h00, 16'd0, 10, 3, 1'b0);
        first_w = -1; last_w = -1; n10 = 0;
        foreach (obs_ui[i]) if (obs_ui[i][7:6] == 2'b01) begin
            if (first_w < 0) first_w = i;
            last_w = i;
        end
        for (int i = first_w + 1; i < last_w; i++) if (obs_ui[i][7:6] == 2'b10) n10++;
        check("wr_stall_cycles", n10, 3);
        check("wr_last_addr", obs_ui[last_w], 8'h57);
        check("wr_done_after_last", done_idx, last_w + 1);

        exec(2'd0, 6'd0, 7'd0, 8'h00, 16'd2560, 0, 0, 1'b0);

        // Reset in the middle of a stalled write.
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 6'd20; cmd_len = 7'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_mid_write", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_pins", {pin_ui, pin_uio}, 16'h0000);
        check("midrst_flags", {done, busy, wr_ready, rd_valid}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_no_done", done, 0);
        exec(2'd3, 6'd0, 7'd0, 8'h33, 16'd0, 0, 0, 1'b0);
        check("post_rst_cfg_ui", obs_ui[0], 8'hC0);
        check("post_rst_cfg_uio", obs_uio[0], 8'h33);

        for (int n = 0; n < 25; n++) begin
            logic [1:0] op;
            logic [7:0] d;
            op = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            exec(op, 6'($urandom), 7'($urandom_range(0, 8)), d, 16'($urandom_range(0, 12)), 0, 0, 1'b1);
            if (op == 2'd3) check("rand_cfg_pins", {obs_ui[0], obs_uio[0]}, {8'hC0, d});
        end

        errs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) errs++;
        check("solver_memory", errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stencil_host_seq.md
STENCIL_HOST_SEQ -- requirements
Module: stencil_host_seq

Interface
REQ-001 Parameter READ_LAT, default 2: cycles from driving a read request on the pins to sampling pin_uio_in.
REQ-002 Parameter RUN_W, default 16: width of the run-length count.
REQ-003 Port clk, input, 1: single clock; every register samples on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port cmd_valid, input, 1: a command is presented.
REQ-006 Port cmd_ready, output, 1: the sequencer accepts a command; high only in IDLE.
REQ-007 Port cmd_op, input, 2: command opcode; 0=RUN, 1=WRITE, 2=READ, 3=CONFIG.
REQ-008 Port cmd_addr, input, 6: start cell address.
REQ-009 Port cmd_len, input, 7: number of cells for WRITE or READ, range 0..64.
REQ-010 Port cmd_data, input, 8: alpha value for CONFIG.
REQ-011 Port run_cycles, input, RUN_W: run length in cycles for RUN.
REQ-012 Port wr_valid, input, 1: write-data beat is valid.
REQ-013 Port wr_data, input, 8: write-data beat value.
REQ-014 Port wr_ready, output, 1: write beat is consumed.
REQ-015 Port rd_valid, output, 1: readback beat is valid.
REQ-016 Port rd_data, output, 8: readback beat value.
REQ-017 Port rd_ready, input, 1: downstream accepts the readback beat.
REQ-018 Port pin_ui, output, 8: drives the solver ui_in; [7:6]=mode, [5:0]=addr.
REQ-019 Port pin_uio, output, 8: drives the solver uio_in data.
REQ-020 Port pin_uio_in, input, 8: the solver uio_out read data.
REQ-021 Port busy, output, 1: high whenever the state is not IDLE.
REQ-022 Port done, output, 1: one-cycle pulse when a command completes.

Function
REQ-023 A command is accepted on cmd_valid AND cmd_ready; the sequencer latches op, addr, len, data and run_cycles on that edge.
REQ-024 States: IDLE, CFG, WR, RUN, RD_REQ, RD_WAIT, RD_OUT.
REQ-025 Pin modes: 00=run, 01=write, 10=read, 11=config; IDLE drives pin_ui=0x00 and pin_uio=0x00.
REQ-026 CFG lasts exactly one cycle with pin_ui=0xC0 and pin_uio=alpha, then returns to IDLE with done.
REQ-027 WR, beat accepted: when wr_valid=1, wr_ready=1, pin_ui={01,addr} and pin_uio=wr_data; addr increments and the remaining count decrements.
REQ-028 WR, stall: when wr_valid=0, pin_ui={10,addr} (harmless read) and wr_ready=0.
REQ-029 The address wraps modulo 64 (63 -> 0).
REQ-030 RUN drives pin_ui=0x00 for exactly run_cycles cycles, then returns to IDLE with done.
REQ-031 READ, per cell: RD_REQ drives {10,addr} for READ_LAT cycles, keeping {10,addr} stable throughout.
REQ-032 READ, capture: after RD_REQ, pin_uio_in is sampled into rd_data; RD_OUT asserts rd_valid.
REQ-033 READ, handshake: rd_valid and rd_data hold until rd_ready; then addr+1, and the next cell is read or the command finishes.
REQ-034 A WRITE or READ with cmd_len=0, and a RUN with run_cycles=0, complete in one cycle with done and no non-IDLE pin activity.
REQ-035 done asserts in the cycle the state returns to IDLE; cmd_ready is low in that cycle and a new command can be accepted one cycle later.
REQ-036 wr_ready=0 outside WR; rd_valid=0 outside RD_OUT.
REQ-037 Commands arriving while busy are not accepted (back-pressured by cmd_ready=0).

Reset
REQ-038 rst_n=0 at a rising clk edge forces IDLE and sets pin_ui=0, pin_uio=0, rd_valid=0, rd_data=0, wr_ready=0, done=0, busy=0, and clears all counters.
REQ-039 A reset mid-command abandons the command with no done pulse; the pins read zero in the first cycle after the reset edge.
REQ-040 cmd_ready=1 from the first cycle after reset is released.

Structure
REQ-041 Package stencil_host_pkg holds the op encodings, the 2-bit pin-mode constants (RUN, WRITE, READ, CONFIG), and the state enum.
REQ-042 The block is a single module with no sub-modules; all pin outputs are registered.

Verification
REQ-043 CONFIG with cmd_data=64 -> one cycle of pin_ui=0xC0 and pin_uio=0x40, then done, then pins back to 0.
REQ-044 WRITE addr=56, len=32, 32 beats of 0xFF with wr_valid low for 3 cycles mid-burst -> addresses 56..63 then 0..23 driven with mode 01; the stall cycles show mode 10; done after the 32nd beat.
REQ-045 RUN with run_cycles=2560 -> pin_ui=0x00 for exactly 2560 cycles, then a single done pulse.
REQ-046 READ addr=8, len=2, with a model returning 0x80 then 0x7F, and rd_ready held low 4 cycles on the first beat -> rd_data 0x80 then 0x7F in order; the second request is issued only after the first handshake.
REQ-047 rst_n low for one cycle mid-WRITE -> pins 0, no done, cmd_ready=1 next cycle, and a following CONFIG executes normally.
REQ-048 WRITE with len=0 -> done one cycle after acceptance; wr_ready is never asserted.
